hex_7seg_scan: RTL and testbench

Multiplexed N-digit hexadecimal 7-segment display driver. It is the parametrised successor of the single-digit hex-to-7-segment decoder. The block latches a packed hex value and time-multiplexes one digit at a time onto a shared active-low segment bus, with per-digit decimal points, global blanking and optional leading-zero suppression. It sits between the datapath and the board-level common-anode display pins.

---
 rtl/hex_7seg_scan.sv | 118 +++++++++++
 tb/tb_hex_7seg_scan.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_7seg_scan.sv
// Multiplexed DIGITS-wide hex display driver: shadowed value/dp, prescaled scan, registered active-low outputs.
// Optional leading-zero blanking is compiled in when SEG_LZB_EN is defined.
module hex_7seg_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(PRESCALE);

    logic [4*DIGITS-1:0] sh_val;
    logic [DIGITS-1:0]   sh_dp;
    logic [PW-1:0]       pcnt;
    logic [IW-1:0]       idx;

    logic [3:0]          digit_p0;
    logic                dpsel_p0;
    logic                suppress_p0;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'b0000001;
            4'h1: decode = 7'b1001111;
            4'h2: decode = 7'b0010010;
            4'h3: decode = 7'b0000110;
            4'h4: decode = 7'b1001100;
            4'h5: decode = 7'b0100100;
            4'h6: decode = 7'b0100000;
            4'h7: decode = 7'b0001111;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0001100;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b1100000;
            4'hC: decode = 7'b0110001;
            4'hD: decode = 7'b1000010;
            4'hE: decode = 7'b0110000;
            default: decode = 7'b0111000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_val <= '0;
            sh_dp  <= '0;
        end else if (load) begin
            sh_val <= value;
            sh_dp  <= dp_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (pcnt == PW'(PRESCALE - 1)) begin
            pcnt <= '0;
            if (idx == IW'(DIGITS - 1))
                idx <= '0;
            else
                idx <= idx + IW'(1);
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    always_comb begin
        digit_p0 = 4'h0;
        dpsel_p0 = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                digit_p0 = sh_val[i*4 +: 4];
                dpsel_p0 = sh_dp[i];
            end
        end
    end

`ifdef SEG_LZB_EN
    // zero_run tracks "every digit from here up to the MSD is zero"
    logic zero_run;
    always_comb begin
        zero_run    = 1'b1;
        suppress_p0 = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (sh_val[i*4 +: 4] == 4'h0);
            if (idx == IW'(i))
                suppress_p0 = zero_run & ~sh_dp[i];
        end
    end
`else
    assign suppress_p0 = 1'b0;
`endif

    // ---- p0 -> output register stage ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (blank || suppress_p0) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= decode(digit_p0);
            dp  <= ~dpsel_p0;
        end
    end
endmodule

// File: tb/tb_hex_7seg_scan.sv
// Randomised self-checking bench for hex_7seg_scan (DIGITS=4, PRESCALE=4) against a cycle-count model.
module tb_hex_7seg_scan;
    localparam int D = 4;
    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    hex_7seg_scan #(.DIGITS(D), .PRESCALE(P)) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
        .load(load), .blank(blank), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: digit on display is simply (edges since reset / P) mod D.
    int          m_edges;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    always @(posedge clk or posedge rst) begin
        int k;
        logic dark;
        logic [3:0] nib;
        if (rst) begin
            m_edges = 0;
            m_val   = '0;
            m_dp    = '0;
            e_an    = 4'hF;
            e_seg   = 7'h7F;
            e_dp    = 1'b1;
        end else begin
            k    = (m_edges / P) % D;
            nib  = m_val[4*k +: 4];
            dark = blank;
`ifdef SEG_LZB_EN
            if (k > 0 && (m_val >> (4*k)) == 16'h0 && !m_dp[k]) dark = 1'b1;
`endif
            if (dark) begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                e_an  = ~(4'b0001 << k);
                e_seg = tbl[nib];
                e_dp  = ~m_dp[k];
            end
            if (load) begin
                m_val = value;
                m_dp  = dp_in;
            end
            m_edges++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("an", an, e_an);
            check("seg", seg, e_seg);
            check("dp", dp, e_dp);
            check("onehot", $countones(~an) <= 1, 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] pat, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (an == pat) ok = 1'b1;
        end
        if (!ok) check(name, an, pat);
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic count_dark(input string name, input int exp);
        int n = 0;
        for (int i = 0; i < D*P; i++) begin
            @(negedge clk);
            if (an == 4'hF) n++;
        end
        check(name, n, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] sweep [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        logic [3:0] prev;
        int run;
        bit first;

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("first_an", an, 4'b1110);
        check("first_seg", seg, 7'b0000001);

        // asynchronous reset mid-scan
        tick(5);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("restart_an", an, 4'b1110);

        // decode sweep
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            load_val(sweep[i], 4'b0000);
            tick(D*P);
        end
        wait_an(4'b0111, "wait_d3");
        check("dec_F", seg, 7'b0111000);

        // dwell and scan order
        prev = an;
        run = 0;
        first = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an == prev) run++;
            else begin
                if (!first) begin
                    check("dwell", run, P);
                    check("order", an, {prev[2:0], prev[3]});
                end
                first = 1'b0;
                prev = an;
                run = 1;
            end
        end

        // load while digit 0 is lit
        wait_an(4'b1101, "wait_d1");
        wait_an(4'b1110, "wait_d0");
        load_val(16'h000A, 4'b0000);
        check("mid_old", seg, 7'b0110001);
        @(negedge clk);
        check("mid_new", seg, 7'b0001000);
        check("mid_an", an, 4'b1110);
        @(negedge clk);
        check("mid_hold", an, 4'b1110);
        @(negedge clk);
        check("mid_next", an, 4'b1101);

        // decimal point and blanking
        load_val(16'h1234, 4'b0100);
        wait_an(4'b1011, "wait_dp");
        check("dp_lit", dp, 1'b0);
        blank = 1'b1;
        @(negedge clk);
        check("blank_an", an, 4'hF);
        check("blank_seg", seg, 7'h7F);
        check("blank_dp", dp, 1'b1);
        tick(5);
        blank = 1'b0;
        tick(8);

        // leading-zero cases
        load_val(16'h0042, 4'b0000);
`ifdef SEG_LZB_EN
        count_dark("lzb_0042", 8);
`else
        count_dark("lzb_0042", 0);
`endif
        load_val(16'h0000, 4'b0000);
`ifdef SEG_LZB_EN
        count_dark("lzb_0000", 12);
`else
        count_dark("lzb_0000", 0);
`endif
        load_val(16'h0400, 4'b1000);
        count_dark("lzb_0400", 0);
        wait_an(4'b0111, "wait_lzb_d3");
        check("lzb_d3_dp", dp, 1'b0);
        check("lzb_d3_seg", seg, 7'b0000001);

        // randomised traffic
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            load  = ($urandom_range(0, 5) == 0);
            value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            blank = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1 check("rnd_rst_an", an, 4'hF);
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        load = 1'b0;
        blank = 1'b0;
        tick(D*P);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
